// File: rtl/mult_entry_ctrl_pkg.sv
// Shared types and constants for the operand-entry multiplier controller.
package mult_ctrl_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {ST_A, ST_B, ST_MUL, ST_SHOW} state_e;

  localparam int STAT_A    = 0;
  localparam int STAT_B    = 1;
  localparam int STAT_MUL  = 2;
  localparam int STAT_SHOW = 3;

  function automatic logic [3:0] state_onehot(input state_e s);
    logic [3:0] oh;
    oh = '0;
    case (s)
      ST_A:    oh[STAT_A]    = 1'b1;
      ST_B:    oh[STAT_B]    = 1'b1;
      ST_MUL:  oh[STAT_MUL]  = 1'b1;
      ST_SHOW: oh[STAT_SHOW] = 1'b1;
      default: oh[STAT_A]    = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mult_entry_ctrl_if.sv
// Board-side bundle: keys and switches in, product and state indication out.
interface mult_entry_ctrl_if #(parameter int N = mult_ctrl_pkg::N_DEF);
  logic [1:0]     KEY;
  logic [N-1:0]   SW;
  logic [2*N-1:0] LED;
  logic [3:0]     STATUS;

  modport master (output KEY, SW, input LED, STATUS);
  modport slave  (input KEY, SW, output LED, STATUS);
endinterface

// File: rtl/mult_entry_ctrl_debounce.sv
// Synchronises and debounces the active-low enter key; emits a 1-cycle press
// pulse on an accepted 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the cycle the mismatch run reaches DEBOUNCE_CYCLES.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
      else                                    cnt_d = cnt_q + 1'b1;
    end
    press_d = deb_q & ~deb_d;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mult_entry_ctrl.sv
// Operand entry FSM and N-cycle shift-and-add multiplier; product held on LED.
module mult_entry_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N               = N_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic              CLOCK_50,
  mult_entry_ctrl_if.slave io
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic           rst_n;
  logic           press;
  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d, led_q, led_d;
  logic [2*N-1:0] a_ext, addend;
  logic [CW-1:0]  cnt_q, cnt_d;

  assign rst_n = io.KEY[1];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .key_in   (io.KEY[0]),
    .press    (press)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    a_ext   = {{N{1'b0}}, a_q};
    addend  = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    case (state_q)
      ST_A: if (press) begin
        a_d     = io.SW;
        state_d = ST_B;
      end
      ST_B: if (press) begin
        b_d     = io.SW;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_MUL;
      end
      // Presses arriving here are dropped; LED only ever sees the final sum.
      ST_MUL: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          led_d   = acc_d;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: if (press) begin
        a_d     = io.SW;
        state_d = ST_B;
      end
      default: state_d = ST_A;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_A;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign io.LED    = led_q;
  assign io.STATUS = state_onehot(state_q);

endmodule
